// File: rtl/mem_sched_pkg.sv
// Shared helpers for the memory port scheduler: round-robin pointer math,
// one-hot decoding and parameter legality limits.
package mem_sched_pkg;

  localparam int MIN_REQUESTERS = 2;
  localparam int MIN_MEM_LAT    = 1;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

  function automatic int onehot_to_idx(input logic [63:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic bit params_legal(input int requesters, input int memLat);
    return (requesters >= MIN_REQUESTERS) && (memLat >= MIN_MEM_LAT);
  endfunction

endpackage

// File: rtl/mem_port_scheduler_if.sv
// Client-side read/write ports and memory-side bus of the scheduler.
interface mem_port_scheduler_if #(
  parameter int REQUESTERS = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [REQUESTERS-1:0]                 r_avalid;
  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [REQUESTERS-1:0]                 r_aready;
  logic [REQUESTERS-1:0]                 r_dvalid;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] r_data;
  logic [REQUESTERS-1:0]                 w_valid;
  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] w_data;
  logic [REQUESTERS-1:0]                 w_ready;
  logic [ADDR_WIDTH-1:0]                 mem_r_addr;
  logic                                  mem_r_avalid;
  logic [DATA_WIDTH-1:0]                 mem_r_data;
  logic [ADDR_WIDTH-1:0]                 mem_w_addr;
  logic [DATA_WIDTH-1:0]                 mem_w_data;
  logic                                  mem_w_valid;

  modport slave (
    input  r_avalid, r_addr, w_valid, w_addr, w_data, mem_r_data,
    output r_aready, r_dvalid, r_data, w_ready,
           mem_r_addr, mem_r_avalid, mem_w_addr, mem_w_data, mem_w_valid
  );

  modport master (
    output r_avalid, r_addr, w_valid, w_addr, w_data, mem_r_data,
    input  r_aready, r_dvalid, r_data, w_ready,
           mem_r_addr, mem_r_avalid, mem_w_addr, mem_w_data, mem_w_valid
  );
endinterface

// File: rtl/mem_port_scheduler_arbiter.sv
// Round-robin arbiter with a grant veto; the pointer only moves on a real grant.
module rr_arbiter
  import mem_sched_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_enable,
  output logic [N-1:0] o_winner,
  output logic [N-1:0] o_grant
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   w_idx;
  logic             w_found;
  logic [N-1:0]     w_winner;

  // o_winner is the pre-veto candidate so the parent can inspect its address.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(N)) w_idx = w_idx - (PTR_W+1)'(N);
      if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
        w_winner[w_idx[PTR_W-1:0]] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

  assign o_winner = w_winner;
  assign o_grant  = i_enable ? w_winner : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (|o_grant) begin
      r_ptr <= PTR_W'(rr_next(onehot_to_idx(64'(o_grant)), N));
    end
  end
endmodule

// File: rtl/mem_port_scheduler.sv
// Shares a pseudo-dual-port memory between clients: independent read/write
// round-robin arbitration, same-address hazard veto and tagged read responses.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int REQUESTERS = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_LAT    = 1
) (
  input logic clk,
  input logic rst,
  mem_port_scheduler_if.slave bus
);
  if (!params_legal(REQUESTERS, MEM_LAT)) begin : g_badParams
    $error("mem_port_scheduler: REQUESTERS must be >= 2 and MEM_LAT >= 1");
  end

  logic [REQUESTERS-1:0] w_rWinner, w_rGrant, w_wWinner, w_wGrant;
  logic [ADDR_WIDTH-1:0] w_rAddrSel, w_wAddrSel;
  logic [DATA_WIDTH-1:0] w_wDataSel;
  logic                  w_hazard;

  logic                  r_memRValid, r_memWValid;
  logic [ADDR_WIDTH-1:0] r_memRAddr, r_memWAddr;
  logic [DATA_WIDTH-1:0] r_memWData;
  logic [REQUESTERS-1:0] r_tag [0:MEM_LAT];

  rr_arbiter #(.N(REQUESTERS)) u_rdArb (
    .clk(clk), .rst(rst), .i_req(bus.r_avalid), .i_enable(~rst & ~w_hazard),
    .o_winner(w_rWinner), .o_grant(w_rGrant)
  );

  rr_arbiter #(.N(REQUESTERS)) u_wrArb (
    .clk(clk), .rst(rst), .i_req(bus.w_valid), .i_enable(~rst),
    .o_winner(w_wWinner), .o_grant(w_wGrant)
  );

  always_comb begin
    w_rAddrSel = '0;
    w_wAddrSel = '0;
    w_wDataSel = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_rWinner[i]) w_rAddrSel = bus.r_addr[i];
      if (w_wWinner[i]) begin
        w_wAddrSel = bus.w_addr[i];
        w_wDataSel = bus.w_data[i];
      end
    end
  end

  // Write wins a same-address collision; the read retries and sees the new data.
  assign w_hazard = (|w_rWinner) && (|w_wGrant) && (w_rAddrSel == w_wAddrSel);

  assign bus.r_aready = w_rGrant;
  assign bus.w_ready  = w_wGrant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memRValid <= 1'b0;
      r_memRAddr  <= '0;
      r_memWValid <= 1'b0;
      r_memWAddr  <= '0;
      r_memWData  <= '0;
      for (int s = 0; s <= MEM_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_memRValid <= |w_rGrant;
      r_memRAddr  <= (|w_rGrant) ? w_rAddrSel : '0;
      r_memWValid <= |w_wGrant;
      r_memWAddr  <= (|w_wGrant) ? w_wAddrSel : '0;
      r_memWData  <= (|w_wGrant) ? w_wDataSel : '0;
      r_tag[0]    <= w_rGrant;
      for (int s = 1; s <= MEM_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign bus.mem_r_avalid = r_memRValid;
  assign bus.mem_r_addr   = r_memRAddr;
  assign bus.mem_w_valid  = r_memWValid;
  assign bus.mem_w_addr   = r_memWAddr;
  assign bus.mem_w_data   = r_memWData;
  assign bus.r_dvalid     = r_tag[MEM_LAT];

  always_comb begin
    for (int i = 0; i < REQUESTERS; i++) begin
      bus.r_data[i] = r_tag[MEM_LAT][i] ? bus.mem_r_data : '0;
    end
  end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed, table-driven check of mem_port_scheduler against a preloaded
// one-cycle-latency memory model (mem[a] = 0x100 + a).
module tb_mem_port_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem [16];
  logic [31:0] memRData;
  int total = 0;
  int bad   = 0;
  int vecIdx = 0;

  always #5 clk = ~clk;

  mem_port_scheduler_if #(.REQUESTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  mem_port_scheduler #(.REQUESTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial for (int a = 0; a < 16; a++) mem[a] = 32'h100 + 32'(a);

  always @(posedge clk) begin
    if (bus.mem_w_valid) mem[bus.mem_w_addr] <= bus.mem_w_data;
    if (bus.mem_r_avalid) memRData <= mem[bus.mem_r_addr];
  end
  assign bus.mem_r_data = memRData;

  typedef struct {
    logic [2:0]  rv;
    logic [11:0] ra;
    logic [2:0]  wv;
    logic [11:0] wa;
    logic [95:0] wd;
    logic [2:0]  rr;
    logic [2:0]  wr;
    logic        mrv;
    logic [3:0]  mra;
    logic        mwv;
    logic [3:0]  mwa;
    logic [31:0] mwd;
    logic [2:0]  dv;
    logic [31:0] dd;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  function automatic vec_t mkVec(logic [2:0] rv, logic [11:0] ra, logic [2:0] wv,
                                 logic [11:0] wa, logic [95:0] wd, logic [2:0] rr,
                                 logic [2:0] wr, logic mrv, logic [3:0] mra, logic mwv,
                                 logic [3:0] mwa, logic [31:0] mwd, logic [2:0] dv,
                                 logic [31:0] dd);
    vec_t v;
    v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
    v.rr = rr; v.wr = wr; v.mrv = mrv; v.mra = mra; v.mwv = mwv;
    v.mwa = mwa; v.mwd = mwd; v.dv = dv; v.dd = dd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.r_avalid = v.rv;
    bus.r_addr   = v.ra;
    bus.w_valid  = v.wv;
    bus.w_addr   = v.wa;
    bus.w_data   = v.wd;
  endtask

  task automatic checkOutput(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %h want %h", nm, vecIdx, act, exp);
    end
  endtask

  function automatic logic [95:0] expData(logic [2:0] dv, logic [31:0] dd);
    return {dv[2] ? dd : 32'h0, dv[1] ? dd : 32'h0, dv[0] ? dd : 32'h0};
  endfunction

  task automatic checkVector(input vec_t v);
    checkOutput("r_aready",     96'(bus.r_aready),     96'(v.rr));
    checkOutput("w_ready",      96'(bus.w_ready),      96'(v.wr));
    checkOutput("mem_r_avalid", 96'(bus.mem_r_avalid), 96'(v.mrv));
    checkOutput("mem_r_addr",   96'(bus.mem_r_addr),   96'(v.mra));
    checkOutput("mem_w_valid",  96'(bus.mem_w_valid),  96'(v.mwv));
    checkOutput("mem_w_addr",   96'(bus.mem_w_addr),   96'(v.mwa));
    checkOutput("mem_w_data",   96'(bus.mem_w_data),   96'(v.mwd));
    checkOutput("r_dvalid",     96'(bus.r_dvalid),     96'(v.dv));
    checkOutput("r_data",       96'(bus.r_data),       expData(v.dv, v.dd));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Read single, then client 2 parks the read pointer at 0 for the fairness run.
    vecs[0]  = mkVec(3'b010, {4'd0,4'd5,4'd0}, 3'b000, 12'h0, 96'h0, 3'b010, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[1]  = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 1, 4'd5, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[2]  = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b010, 32'h105);
    vecs[3]  = mkVec(3'b100, {4'd7,4'd0,4'd0}, 3'b000, 12'h0, 96'h0, 3'b100, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[4]  = mkVec(3'b111, {4'd2,4'd1,4'd0}, 3'b000, 12'h0, 96'h0, 3'b001, 3'b000, 1, 4'd7, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[5]  = mkVec(3'b111, {4'd2,4'd1,4'd0}, 3'b000, 12'h0, 96'h0, 3'b010, 3'b000, 1, 4'd0, 0, 4'd0, 32'h0, 3'b100, 32'h107);
    vecs[6]  = mkVec(3'b111, {4'd2,4'd1,4'd0}, 3'b000, 12'h0, 96'h0, 3'b100, 3'b000, 1, 4'd1, 0, 4'd0, 32'h0, 3'b001, 32'h100);
    vecs[7]  = mkVec(3'b111, {4'd2,4'd1,4'd0}, 3'b000, 12'h0, 96'h0, 3'b001, 3'b000, 1, 4'd2, 0, 4'd0, 32'h0, 3'b010, 32'h101);
    vecs[8]  = mkVec(3'b111, {4'd2,4'd1,4'd0}, 3'b000, 12'h0, 96'h0, 3'b010, 3'b000, 1, 4'd0, 0, 4'd0, 32'h0, 3'b100, 32'h102);
    vecs[9]  = mkVec(3'b111, {4'd2,4'd1,4'd0}, 3'b000, 12'h0, 96'h0, 3'b100, 3'b000, 1, 4'd1, 0, 4'd0, 32'h0, 3'b001, 32'h100);
    vecs[10] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 1, 4'd2, 0, 4'd0, 32'h0, 3'b010, 32'h101);
    vecs[11] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b100, 32'h102);
    // Same-address hazard, then disjoint read/write in one cycle.
    vecs[12] = mkVec(3'b001, {4'd0,4'd0,4'd3}, 3'b100, {4'd3,4'd0,4'd0}, {32'hDEADBEEF,32'h0,32'h0}, 3'b000, 3'b100, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[13] = mkVec(3'b001, {4'd0,4'd0,4'd3}, 3'b000, 12'h0, 96'h0, 3'b001, 3'b000, 0, 4'd0, 1, 4'd3, 32'hDEADBEEF, 3'b000, 32'h0);
    vecs[14] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 1, 4'd3, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[15] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b001, 32'hDEADBEEF);
    vecs[16] = mkVec(3'b001, {4'd0,4'd0,4'd4}, 3'b010, {4'd0,4'd3,4'd0}, {32'h0,32'h55AA55AA,32'h0}, 3'b001, 3'b010, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[17] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 1, 4'd4, 1, 4'd3, 32'h55AA55AA, 3'b000, 32'h0);
    vecs[18] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b001, 32'h104);
    // Client 2 parks the write pointer at 0, then clients 0 and 2 alternate.
    vecs[19] = mkVec(3'b000, 12'h0, 3'b100, {4'd10,4'd0,4'd0}, {32'hC2,32'h0,32'h0}, 3'b000, 3'b100, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0);
    vecs[20] = mkVec(3'b000, 12'h0, 3'b101, {4'd9,4'd0,4'd8}, {32'hA2,32'h0,32'hA0}, 3'b000, 3'b001, 0, 4'd0, 1, 4'd10, 32'hC2, 3'b000, 32'h0);
    vecs[21] = mkVec(3'b000, 12'h0, 3'b101, {4'd9,4'd0,4'd8}, {32'hA2,32'h0,32'hA0}, 3'b000, 3'b100, 0, 4'd0, 1, 4'd8, 32'hA0, 3'b000, 32'h0);
    vecs[22] = mkVec(3'b000, 12'h0, 3'b101, {4'd9,4'd0,4'd8}, {32'hA2,32'h0,32'hA0}, 3'b000, 3'b001, 0, 4'd0, 1, 4'd9, 32'hA2, 3'b000, 32'h0);
    vecs[23] = mkVec(3'b000, 12'h0, 3'b101, {4'd9,4'd0,4'd8}, {32'hA2,32'h0,32'hA0}, 3'b000, 3'b100, 0, 4'd0, 1, 4'd8, 32'hA0, 3'b000, 32'h0);
    vecs[24] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 1, 4'd9, 32'hA2, 3'b000, 32'h0);
    vecs[25] = mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0);

    bus.r_avalid = '0; bus.r_addr = '0; bus.w_valid = '0; bus.w_addr = '0; bus.w_data = '0;

    // Grants must be suppressed while reset is held, even with requests present.
    @(posedge clk); #1;
    bus.r_avalid = 3'b111; bus.w_valid = 3'b111;
    @(negedge clk);
    checkOutput("rst_r_aready", 96'(bus.r_aready), 96'h0);
    checkOutput("rst_w_ready",  96'(bus.w_ready),  96'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0));
    @(negedge clk);
    checkVector(mkVec(3'b000, 12'h0, 3'b000, 12'h0, 96'h0, 3'b000, 3'b000, 0, 4'd0, 0, 4'd0, 32'h0, 3'b000, 32'h0));

    for (int n = 0; n < NVEC; n++) begin
      vecIdx = n;
      @(posedge clk); #1;
      applyStimulus(vecs[n]);
      @(negedge clk);
      checkVector(vecs[n]);
    end

    // Reset one cycle after a read handshake must swallow its response.
    vecIdx = 100;
    @(posedge clk); #1;
    bus.r_avalid = 3'b010; bus.r_addr = {4'd0,4'd6,4'd0};
    @(negedge clk);
    checkOutput("pre_rst_r_aready", 96'(bus.r_aready), 96'(3'b010));

    vecIdx = 101;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.r_avalid = 3'b111; bus.r_addr = {4'd2,4'd1,4'd0}; bus.w_valid = 3'b111;
    @(negedge clk);
    checkOutput("mid_rst_r_aready", 96'(bus.r_aready), 96'h0);
    checkOutput("mid_rst_w_ready",  96'(bus.w_ready),  96'h0);

    vecIdx = 102;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.w_valid = 3'b000;
    @(negedge clk);
    checkOutput("post_rst_r_dvalid",     96'(bus.r_dvalid),     96'h0);
    checkOutput("post_rst_mem_r_avalid", 96'(bus.mem_r_avalid), 96'h0);
    checkOutput("post_rst_r_aready",     96'(bus.r_aready),     96'(3'b001));

    vecIdx = 103;
    @(posedge clk); #1;
    bus.r_avalid = 3'b000;
    @(negedge clk);
    checkOutput("post_rst_r_dvalid2", 96'(bus.r_dvalid),     96'h0);
    checkOutput("post_rst_mem_r",     96'(bus.mem_r_avalid), 96'h1);

    vecIdx = 104;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_rst_r_dvalid3", 96'(bus.r_dvalid), 96'(3'b001));
    checkOutput("post_rst_r_data",    96'(bus.r_data),   expData(3'b001, 32'h100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_scheduler.md
# mem_port_scheduler

Shares one pseudo-dual-port memory between REQUESTERS clients, each with its own read and write port. Two independent round-robin arbiters issue at most one read and one write to the memory per cycle. Registered memory-side outputs resolve same-address read/write hazards, and a tag pipeline routes each read response back to the requester that issued it. It sits between the client ports and a `pseudo_dual_port_memory` instance.

## Interface
Parameters:
- REQUESTERS, 3, number of clients (≥2)
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 4, address width
- MEM_LAT, 1, memory read latency in cycles, from mem_r_avalid to mem_r_data (≥1)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r_avalid  in  REQUESTERS  read request per client
- r_addr  in  REQUESTERS×ADDR_WIDTH  read address per client
- r_aready  out  REQUESTERS  read grant (combinational)
- r_dvalid  out  REQUESTERS  read data valid per client
- r_data  out  REQUESTERS×DATA_WIDTH  read data per client
- w_valid  in  REQUESTERS  write request per client
- w_addr  in  REQUESTERS×ADDR_WIDTH  write address
- w_data  in  REQUESTERS×DATA_WIDTH  write data
- w_ready  out  REQUESTERS  write grant (combinational)
- mem_r_addr  out  ADDR_WIDTH  memory read address
- mem_r_avalid  out  1  memory read strobe
- mem_r_data  in  DATA_WIDTH  memory read data
- mem_w_addr  out  ADDR_WIDTH  memory write address
- mem_w_data  out  DATA_WIDTH  memory write data
- mem_w_valid  out  1  memory write strobe

## Operation
- **Handshake:** a transfer occurs on a rising edge where valid and ready are both high. r_aready and w_ready are each one-hot or zero, and depend combinationally on the request inputs in the same cycle.
- **Arbitration:** read and write each use round-robin with their own priority pointer.
  - Search starts at the pointer and wraps modulo REQUESTERS.
  - After a grant to client i, the pointer becomes (i+1) mod REQUESTERS.
  - The pointer holds when there is no grant.
- **Hazard rule:** if the read winner's r_addr equals the write winner's w_addr in the same cycle, the write is granted and r_aready is forced to 0.
  - The read arbiter pointer does not advance.
  - The read is retried next cycle and returns the newly written data.
  - A read and a write to different addresses are both granted.
- **Memory-side outputs:**
  - mem_* registers are loaded from the granted client on the cycle after the handshake.
  - mem_r_addr, mem_w_addr and mem_w_data are 0 whenever the matching strobe is 0.
- **Response routing:**
  - A one-hot tag pipeline of depth 1+MEM_LAT is loaded with r_aready on each read handshake and with 0 otherwise.
  - Its last stage drives r_dvalid.
  - r_data[i] equals mem_r_data while r_dvalid[i]=1; otherwise it is 0.
- **Ordering:** responses return in issue order, at most one per cycle. There is no backpressure on responses.

## Timing
- Read handshake at edge T:
  - mem_r_avalid=1 with the address during cycle T+1.
  - r_dvalid[i]=1 during cycle T+1+MEM_LAT.
- Write handshake at edge T: mem_w_valid=1 during cycle T+1, and the memory commits at the end of T+1.
- Throughput: one read and one write per cycle, sustained.
- Reset values: every registered output is 0 (mem_r_avalid, mem_w_valid, mem_* addresses and data). r_dvalid=0 and r_data=0. Tag pipeline cleared; both pointers at client 0.
- Reset mid-operation:
  - In-flight reads are discarded; no r_dvalid is produced for them, even if the memory returns data.
  - r_aready and w_ready are 0 while rst=1.

## Structure
- Package `mem_sched_pkg` holds:
  - the `rr_next` pointer-increment function;
  - the one-hot-to-index function;
  - the MEM_LAT ≥ 1 and REQUESTERS ≥ 2 legality checks.
- Sub-module `rr_arbiter` (REQUESTERS param; inputs req and an enable used to veto the grant; output grant) is instantiated twice, for read and write. The hazard veto suppresses the read arbiter's grant and pointer update.
- Tag pipeline, registered memory outputs and data gating live in the top module.

## Test plan
All scenarios use REQUESTERS=3 and MEM_LAT=1, with memory preloaded mem[a]=0x100+a.
1. **Reset and single read:** release reset and check every output is 0. Client 1 reads addr 5 at T → r_aready=3'b010 at T; mem_r_avalid=1 with addr 5 in T+1; r_dvalid=3'b010 with r_data[1]=0x105 in T+2; other r_data=0.
2. **Read fairness:** all three r_avalid held high for 6 cycles → grants 0,1,2,0,1,2. r_dvalid shows the same sequence, delayed 2 cycles, with matching data.
3. **Same-address hazard:** client 2 writes 0xDEADBEEF to addr 3 while client 0 reads addr 3 in the same cycle → w_ready=3'b100 and r_aready=0. Next cycle r_aready=3'b001; the read returns 0xDEADBEEF.
4. **Different addresses:** read addr 4 (client 0) and write addr 3 (client 1) in the same cycle → both granted; read returns 0x104.
5. **Write fairness:** clients 0 and 2 hold w_valid → grants alternate 0,2,0,2; mem_w_addr and mem_w_data track the grants one cycle later.
6. **Reset mid-read:** assert rst one cycle after a read handshake → r_dvalid stays 0. After reset, the first grant goes to client 0.
